// File: rtl/multi_alarm.sv
// multi_alarm: N independent hh:mm alarm channels with per-channel ring timeout.
// Define MULTI_ALARM_SNOOZE_EN to build the SNOOZED state and per-channel snooze counters.
module multi_alarm #(
  parameter int N_ALARMS   = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  localparam int SEL_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [1:0]          edit_btns,
  input  logic                en_btn,
  input  logic                stop_btn,
  input  logic                snooze_btn,
  input  logic                sec_tick,
  input  logic [16:0]         current_time,
  output logic [16:0]         alarm_time,
  output logic [N_ALARMS-1:0] alarm_en,
  output logic [N_ALARMS-1:0] ringing,
  output logic                alarm
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1
`ifdef MULTI_ALARM_SNOOZE_EN
    , ST_SNOOZED = 2'd2
`endif
  } state_e;

  localparam logic [8:0] RING_LAST = 9'(RING_SECS);

  logic [4:0]          hour_q     [N_ALARMS];
  logic [4:0]          hour_d     [N_ALARMS];
  logic [5:0]          min_q      [N_ALARMS];
  logic [5:0]          min_d      [N_ALARMS];
  state_e              state_q    [N_ALARMS];
  state_e              state_d    [N_ALARMS];
  logic [7:0]          ring_cnt_q [N_ALARMS];
  logic [7:0]          ring_cnt_d [N_ALARMS];
  logic [N_ALARMS-1:0] en_q, en_d;
  logic [N_ALARMS-1:0] match, match_q, trig, sel_hit, dis;
  logic [N_ALARMS-1:0] ringing_q, ringing_d;
  logic                alarm_q, alarm_d;

`ifdef MULTI_ALARM_SNOOZE_EN
  localparam logic [10:0] SNOOZE_LOAD = 11'(SNOOZE_MIN * 60);
  logic [10:0] snz_cnt_q [N_ALARMS];
  logic [10:0] snz_cnt_d [N_ALARMS];
`else
  logic unused_snooze;
  assign unused_snooze = snooze_btn;
`endif

  // Trigger fires only on the rising edge of a match, so a held time rings once.
  always_comb begin
    sel_hit = '0;
    match   = '0;
    trig    = '0;
    dis     = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      sel_hit[i] = (sel == SEL_W'(i));
      match[i]   = (current_time == {hour_q[i], min_q[i], 6'b0});
      trig[i]    = match[i] & ~match_q[i] & en_q[i] & ~mode;
      dis[i]     = en_btn & sel_hit[i] & en_q[i];
    end
  end

  always_comb begin
    alarm_time = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (sel_hit[i]) alarm_time = {hour_q[i], min_q[i], 6'b0};
    end
  end

  always_comb begin
    en_d      = en_q;
    ringing_d = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      hour_d[i]     = hour_q[i];
      min_d[i]      = min_q[i];
      state_d[i]    = state_q[i];
      ring_cnt_d[i] = ring_cnt_q[i];
`ifdef MULTI_ALARM_SNOOZE_EN
      snz_cnt_d[i]  = snz_cnt_q[i];
`endif
      if (mode && sel_hit[i]) begin
        if (edit_btns[1]) hour_d[i] = (hour_q[i] == 5'd23) ? 5'd0 : hour_q[i] + 5'd1;
        if (edit_btns[0]) min_d[i]  = (min_q[i] == 6'd59) ? 6'd0 : min_q[i] + 6'd1;
      end
      if (en_btn && sel_hit[i]) en_d[i] = ~en_q[i];

      // Priority: disable > stop > snooze > timeout/expiry > tick counting.
      if (dis[i]) begin
        state_d[i]    = ST_IDLE;
        ring_cnt_d[i] = '0;
`ifdef MULTI_ALARM_SNOOZE_EN
        snz_cnt_d[i]  = '0;
`endif
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (trig[i]) begin
              state_d[i]    = ST_RINGING;
              ring_cnt_d[i] = '0;
            end
          end
          ST_RINGING: begin
            if (stop_btn) begin
              state_d[i]    = ST_IDLE;
              ring_cnt_d[i] = '0;
            end
`ifdef MULTI_ALARM_SNOOZE_EN
            else if (snooze_btn) begin
              state_d[i]    = ST_SNOOZED;
              ring_cnt_d[i] = '0;
              snz_cnt_d[i]  = SNOOZE_LOAD;
            end
`endif
            else if (sec_tick) begin
              if (({1'b0, ring_cnt_q[i]} + 9'd1) == RING_LAST) begin
                state_d[i]    = ST_IDLE;
                ring_cnt_d[i] = '0;
              end else begin
                ring_cnt_d[i] = ring_cnt_q[i] + 8'd1;
              end
            end
          end
`ifdef MULTI_ALARM_SNOOZE_EN
          ST_SNOOZED: begin
            if (stop_btn) begin
              state_d[i]   = ST_IDLE;
              snz_cnt_d[i] = '0;
            end else if (sec_tick) begin
              snz_cnt_d[i] = snz_cnt_q[i] - 11'd1;
              if (snz_cnt_q[i] == 11'd1) begin
                state_d[i]    = ST_RINGING;
                ring_cnt_d[i] = '0;
              end
            end
          end
`endif
          default: state_d[i] = ST_IDLE;
        endcase
      end
      ringing_d[i] = (state_d[i] == ST_RINGING);
    end
  end

  assign alarm_d = |ringing_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        hour_q[i]     <= '0;
        min_q[i]      <= '0;
        state_q[i]    <= ST_IDLE;
        ring_cnt_q[i] <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
        snz_cnt_q[i]  <= '0;
`endif
      end
      en_q      <= '0;
      match_q   <= '0;
      ringing_q <= '0;
      alarm_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_ALARMS; i++) begin
        hour_q[i]     <= hour_d[i];
        min_q[i]      <= min_d[i];
        state_q[i]    <= state_d[i];
        ring_cnt_q[i] <= ring_cnt_d[i];
`ifdef MULTI_ALARM_SNOOZE_EN
        snz_cnt_q[i]  <= snz_cnt_d[i];
`endif
      end
      en_q      <= en_d;
      match_q   <= match;
      ringing_q <= ringing_d;
      alarm_q   <= alarm_d;
    end
  end

  assign alarm_en = en_q;
  assign ringing  = ringing_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_multi_alarm.sv
// Scoreboard bench for multi_alarm: directed scenarios plus randomized traffic against a
// seconds-remaining reference model.
module tb_multi_alarm;

  localparam int N          = 4;
  localparam int RING_SECS  = 60;
  localparam int SNOOZE_MIN = 5;
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [1:0]  edit_btns = 2'b00;
  logic        en_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic        snooze_btn = 1'b0;
  logic        sec_tick = 1'b0;
  logic [16:0] current_time = '0;
  logic [16:0] alarm_time;
  logic [N-1:0] alarm_en;
  logic [N-1:0] ringing;
  logic        alarm;

  multi_alarm #(.N_ALARMS(N), .RING_SECS(RING_SECS), .SNOOZE_MIN(SNOOZE_MIN)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .edit_btns(edit_btns),
    .en_btn(en_btn), .stop_btn(stop_btn), .snooze_btn(snooze_btn), .sec_tick(sec_tick),
    .current_time(current_time), .alarm_time(alarm_time), .alarm_en(alarm_en),
    .ringing(ringing), .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] ring;
    logic         alrm;
    logic [16:0]  atime;
    logic [N-1:0] aen;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a channel is ringing while ring_left > 0, snoozed while snz_left > 0.
  int hh[N], mm[N], ring_left[N], snz_left[N];
  bit en_m[N], pm[N];

  function automatic logic [16:0] tt(int h, int m, int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      hh[i] = 0; mm[i] = 0; ring_left[i] = 0; snz_left[i] = 0; en_m[i] = 0; pm[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit mt, trg, dis, was_r, was_s;
      mt    = (current_time == tt(hh[i], mm[i], 0));
      trg   = mt && !pm[i] && en_m[i] && !mode;
      dis   = en_btn && (sel == i) && en_m[i];
      was_r = ring_left[i] > 0;
      was_s = snz_left[i] > 0;
      if (en_btn && sel == i) en_m[i] = !en_m[i];
      if (mode && sel == i) begin
        if (edit_btns[1]) hh[i] = (hh[i] + 1) % 24;
        if (edit_btns[0]) mm[i] = (mm[i] + 1) % 60;
      end
      if (dis) begin
        ring_left[i] = 0; snz_left[i] = 0;
      end else if (was_r) begin
        if (stop_btn) ring_left[i] = 0;
        else if (snooze_btn && SNZ) begin ring_left[i] = 0; snz_left[i] = SNOOZE_MIN * 60; end
        else if (sec_tick) ring_left[i] = ring_left[i] - 1;
      end else if (was_s) begin
        if (stop_btn) snz_left[i] = 0;
        else if (sec_tick) begin
          snz_left[i] = snz_left[i] - 1;
          if (snz_left[i] == 0) ring_left[i] = RING_SECS;
        end
      end else if (trg) begin
        ring_left[i] = RING_SECS;
      end
      pm[i] = mt;
    end
  endtask

  // One clock: model advances on the edge and queues what the DUT must show after it.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_step();
    for (int i = 0; i < N; i++) begin
      e.ring[i] = (ring_left[i] > 0);
      e.aen[i]  = en_m[i];
    end
    e.alrm  = |e.ring;
    e.atime = tt(hh[sel], mm[sel], 0);
    exp_q.push_back(e);
    @(negedge clk);
    edit_btns = 2'b00; en_btn = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0; sec_tick = 1'b0;
  endtask

  task automatic do_reset();
    sel = 2'd0;
    reset = 1'b0;
    #1;
    chk("rst_ringing", 32'(ringing), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_alarm_en", 32'(alarm_en), 0);
    chk("rst_alarm_time", 32'(alarm_time), 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_time(int ch, int h, int m);
    int nh, nm;
    nh = (h - hh[ch] + 24) % 24;
    nm = (m - mm[ch] + 60) % 60;
    mode = 1'b1;
    sel  = 2'(ch);
    repeat (nh) begin edit_btns = 2'b10; cycle(); end
    repeat (nm) begin edit_btns = 2'b01; cycle(); end
    mode = 1'b0;
  endtask

  task automatic enable_ch(int ch);
    sel = 2'(ch);
    en_btn = 1'b1;
    cycle();
  endtask

  // Monitor: every edge that had stimulus produces one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ringing", 32'(ringing), 32'(e.ring));
        chk("alarm", 32'(alarm), 32'(e.alrm));
        chk("alarm_time", 32'(alarm_time), 32'(e.atime));
        chk("alarm_en", 32'(alarm_en), 32'(e.aen));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Edit wrap: 24 hour pulses return to 0, 61 minute pulses land on 1, no carry.
    mode = 1'b1; sel = 2'd2;
    repeat (24) begin edit_btns = 2'b10; cycle(); end
    repeat (61) begin edit_btns = 2'b01; cycle(); end
    chk("edit_wrap_ch2", 32'(alarm_time), 32'h40);
    for (int c = 0; c < N; c++) begin
      sel = 2'(c);
      cycle();
      if (c != 2) chk("other_ch_zero", 32'(alarm_time), 0);
    end
    mode = 1'b0;

    // Basic ring and RING_SECS timeout.
    do_reset();
    current_time = tt(7, 29, 59);
    set_time(0, 7, 30);
    enable_ch(0);
    cycle();
    current_time = tt(7, 30, 0);
    cycle();
    chk("ring_on_match", 32'(ringing), 32'h1);
    chk("alarm_on_match", 32'(alarm), 1);
    current_time = tt(7, 30, 1);
    repeat (RING_SECS - 1) begin sec_tick = 1'b1; cycle(); end
    chk("ring_before_timeout", 32'(ringing[0]), 1);
    sec_tick = 1'b1; cycle();
    chk("ring_after_timeout", 32'(ringing[0]), 0);
    chk("alarm_after_timeout", 32'(alarm), 0);

    // Stop inside the match window must not retrigger.
    current_time = tt(7, 30, 0);
    cycle();
    chk("retrigger_new_window", 32'(ringing), 32'h1);
    stop_btn = 1'b1; cycle();
    chk("stop_clears", 32'(ringing), 0);
    repeat (5) cycle();
    chk("no_retrigger", 32'(ringing), 0);

`ifdef MULTI_ALARM_SNOOZE_EN
    do_reset();
    current_time = tt(8, 14, 59);
    set_time(1, 8, 15);
    enable_ch(1);
    cycle();
    current_time = tt(8, 15, 0);
    cycle();
    chk("snz_ring", 32'(ringing), 32'h2);
    current_time = tt(8, 15, 1);
    snooze_btn = 1'b1; cycle();
    chk("snz_off", 32'(ringing[1]), 0);
    repeat (SNOOZE_MIN * 60 - 1) begin sec_tick = 1'b1; cycle(); end
    chk("snz_before_expiry", 32'(ringing[1]), 0);
    sec_tick = 1'b1; cycle();
    chk("snz_expiry_rings", 32'(ringing[1]), 1);
    stop_btn = 1'b1; snooze_btn = 1'b1; cycle();
    chk("stop_beats_snooze", 32'(ringing), 0);
    chk("stop_beats_snooze_alarm", 32'(alarm), 0);
`else
    do_reset();
    current_time = tt(8, 14, 59);
    set_time(1, 8, 15);
    enable_ch(1);
    cycle();
    current_time = tt(8, 15, 0);
    cycle();
    snooze_btn = 1'b1; cycle();
    chk("snooze_ignored", 32'(ringing), 32'h2);
    stop_btn = 1'b1; cycle();
`endif

    // Two channels on the same time ring together; disabling one leaves the other.
    do_reset();
    current_time = tt(5, 59, 59);
    set_time(0, 6, 0);
    set_time(3, 6, 0);
    enable_ch(0);
    enable_ch(3);
    cycle();
    current_time = tt(6, 0, 0);
    cycle();
    chk("dual_ring", 32'(ringing), 32'h9);
    sel = 2'd3; en_btn = 1'b1; cycle();
    chk("disable_ch3", 32'(ringing), 32'h1);
    chk("disable_alarm", 32'(alarm), 1);
    chk("disable_en", 32'(alarm_en), 32'h1);

    // Edit mode blocks triggers but not ringing in progress; reset aborts asynchronously.
    current_time = tt(6, 0, 1);
    stop_btn = 1'b1; cycle();
    mode = 1'b1; current_time = tt(6, 0, 0);
    cycle();
    chk("mode1_no_trigger", 32'(ringing), 0);
    mode = 1'b0; current_time = tt(6, 0, 1); cycle();
    current_time = tt(6, 0, 0); cycle();
    chk("mode0_trigger", 32'(ringing), 32'h1);
    mode = 1'b1;
    repeat (3) cycle();
    chk("mode1_keeps_ring", 32'(ringing), 32'h1);
    mode = 1'b0;
    do_reset();

    // Randomized traffic; a third of the cycles present a channel's own time.
    repeat (4000) begin
      int c;
      mode       = ($urandom_range(0, 7) == 0);
      sel        = 2'($urandom_range(0, 3));
      edit_btns  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      en_btn     = ($urandom_range(0, 23) == 0);
      stop_btn   = ($urandom_range(0, 79) == 0);
      snooze_btn = ($urandom_range(0, 39) == 0);
      sec_tick   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) begin
        c = int'($urandom_range(0, N - 1));
        current_time = tt(hh[c], mm[c], int'($urandom_range(0, 1)));
      end else begin
        current_time = tt(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                          int'($urandom_range(0, 59)));
      end
      cycle();
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #5;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
